// File: rtl/ldtu_ofifo_lanes.sv
// ldtu_ofifo_lanes -- LiTE-DTU output stage.
// Buffers encoded words from the control unit in a DEPTH-word circular FIFO
// and deals them round-robin onto NLANES serializer lanes, one lane per
// read_strobe. A runtime mode selects DTU data, ATU test pattern, idle
// filler or flush. Dropped writes are tracked by a sticky flag and a
// saturating counter.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   mode            00=DTU 01=ATU 10=IDLE 11=FLUSH
//   write_signal    push data_in this cycle
//   data_in         word from control unit
//   read_strobe     serializer request: load next lane word(s)
//   ATU_IN          test pattern, lane i = [i*NBITS +: NBITS]
//   DATA_OUT        registered lane words, same slicing as ATU_IN
//   full/empty/level  registered FIFO occupancy
//   losing_data     sticky drop flag (cleared by RST or FLUSH)
//   ovf_cnt         saturating dropped-write count

// One output lane register; loads d when ld is set, otherwise holds.
module ldtu_ofifo_lane #(
   parameter int               NBITS     = 32,
   parameter logic [NBITS-1:0] IDLE_WORD = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ld,
   input  logic [NBITS-1:0] d,
   output logic [NBITS-1:0] q
);
   always_ff @(posedge CLK) begin
      if (RST)     q <= IDLE_WORD;
      else if (ld) q <= d;
   end
endmodule

module ldtu_ofifo_lanes #(
   parameter int               NBITS     = 32,
   parameter int               NLANES    = 4,
   parameter int               DEPTH     = 16,
   parameter int               PTR_BITS  = 4,
   parameter logic [NBITS-1:0] IDLE_WORD = NBITS'(32'hEAAAAAAA)
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [1:0]              mode,
   input  logic                    write_signal,
   input  logic [NBITS-1:0]        data_in,
   input  logic                    read_strobe,
   input  logic [NLANES*NBITS-1:0] ATU_IN,
   output logic [NLANES*NBITS-1:0] DATA_OUT,
   output logic                    full,
   output logic                    empty,
   output logic [PTR_BITS:0]       level,
   output logic                    losing_data,
   output logic [7:0]              ovf_cnt
);
   localparam int SEL_W = (NLANES > 1) ? $clog2(NLANES) : 1;
   localparam logic [1:0] M_DTU = 2'b00, M_ATU = 2'b01, M_FLUSH = 2'b11;

   typedef struct packed {
      logic             ld;
      logic [NBITS-1:0] d;
   } lane_req_t;

   logic [NBITS-1:0]             mem [DEPTH];
   logic [PTR_BITS-1:0]          rd_ptr, wr_ptr;
   logic [PTR_BITS:0]            level_nxt;
   logic [SEL_W-1:0]             lane_sel, eff_sel, nxt_sel;
   logic [1:0]                   mode_q;
   logic                         mode_chg, flush, pop, push, drop;
   logic [NLANES-1:0][NBITS-1:0] atu, lane_q;
   logic [NBITS-1:0]             head;

   assign atu      = ATU_IN;
   assign DATA_OUT = lane_q;
   assign head     = mem[rd_ptr];

   // A mode change restarts the lane rotation; a strobe on that same edge
   // already targets lane 0.
   assign mode_chg = (mode != mode_q);
   assign flush    = (mode == M_FLUSH);
   assign eff_sel  = mode_chg ? '0 : lane_sel;
   assign nxt_sel  = (eff_sel == SEL_W'(NLANES - 1)) ? '0 : eff_sel + 1'b1;

   // Pop only in DTU mode. A full FIFO still takes a write when it pops in
   // the same cycle (full implies non-empty, so pop is possible then).
   assign pop  = read_strobe && (mode == M_DTU) && !empty;
   assign push = write_signal && !flush && (!full || pop);
   assign drop = write_signal && !flush && full && !pop;

   assign level_nxt = level + {{PTR_BITS{1'b0}}, push} - {{PTR_BITS{1'b0}}, pop};

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         level       <= '0;
         empty       <= 1'b1;
         full        <= 1'b0;
         losing_data <= 1'b0;
         ovf_cnt     <= '0;
         lane_sel    <= '0;
         mode_q      <= M_DTU;
      end else begin
         mode_q <= mode;
         if (read_strobe && (mode == M_DTU)) lane_sel <= nxt_sel;
         else if (mode_chg)                  lane_sel <= '0;

         if (flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            losing_data <= 1'b0;
            ovf_cnt     <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            empty <= (level_nxt == '0);
            full  <= (level_nxt == (PTR_BITS+1)'(DEPTH));
            if (drop) begin
               losing_data <= 1'b1;
               if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
            end
         end
      end
   end

   // Storage is not reset; pointers alone define validity. When full, a
   // simultaneous write and pop share an address: the lane takes the old
   // head (combinational read) while the new word overwrites it.
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   for (genvar i = 0; i < NLANES; i++) begin : g_lane
      lane_req_t req;

      always_comb begin
         req.ld = 1'b0;
         req.d  = IDLE_WORD;
         if (read_strobe) begin
            case (mode)
               M_DTU: begin
                  req.ld = (eff_sel == SEL_W'(i));
                  req.d  = empty ? IDLE_WORD : head;
               end
               M_ATU: begin
                  req.ld = 1'b1;
                  req.d  = atu[i];
               end
               default: req.ld = 1'b1;   // IDLE and FLUSH drive filler
            endcase
         end
      end

      ldtu_ofifo_lane #(.NBITS(NBITS), .IDLE_WORD(IDLE_WORD)) u_lane (
         .CLK (CLK),
         .RST (RST),
         .ld  (req.ld),
         .d   (req.d),
         .q   (lane_q[i])
      );
   end
endmodule

// File: tb/tb_ldtu_ofifo_lanes.sv
// Self-checking bench for ldtu_ofifo_lanes: directed test-plan sequences
// with literal expectations, then randomized traffic, all compared every
// cycle against a queue-based model of the output stage.
module tb_ldtu_ofifo_lanes;
   localparam int NB = 32, NL = 4, DEPTH = 16, PB = 4;
   localparam logic [31:0] IDLE = 32'hEAAAAAAA;

   logic           CLK = 1'b0, RST = 1'b1;
   logic [1:0]     mode = 2'b00;
   logic           write_signal = 1'b0, read_strobe = 1'b0;
   logic [NB-1:0]  data_in = '0;
   logic [NL*NB-1:0] ATU_IN = '0;
   logic [NL*NB-1:0] DATA_OUT;
   logic           full, empty, losing_data;
   logic [PB:0]    level;
   logic [7:0]     ovf_cnt;

   int checks = 0, errors = 0;

   // model state
   logic [31:0] q[$];
   logic [31:0] m_lane[NL];
   int          m_sel, m_ovf;
   logic [1:0]  m_pmode;
   logic        m_losing;

   ldtu_ofifo_lanes #(.NBITS(NB), .NLANES(NL), .DEPTH(DEPTH), .PTR_BITS(PB),
                      .IDLE_WORD(IDLE)) dut (
      .CLK(CLK), .RST(RST), .mode(mode), .write_signal(write_signal),
      .data_in(data_in), .read_strobe(read_strobe), .ATU_IN(ATU_IN),
      .DATA_OUT(DATA_OUT), .full(full), .empty(empty), .level(level),
      .losing_data(losing_data), .ovf_cnt(ovf_cnt));

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] lane(input int i);
      return DATA_OUT[i*NB +: NB];
   endfunction

   // Behaviour at one clock edge, from the rules: queue semantics, pop
   // before push, drops only when the queue is at DEPTH after any pop.
   task automatic model_edge();
      if (RST) begin
         q.delete();
         for (int i = 0; i < NL; i++) m_lane[i] = IDLE;
         m_sel = 0; m_pmode = 2'b00; m_losing = 1'b0; m_ovf = 0;
         return;
      end
      if (mode != m_pmode) m_sel = 0;
      m_pmode = mode;
      if (mode == 2'b11) begin
         q.delete(); m_losing = 1'b0; m_ovf = 0;
         if (read_strobe) for (int i = 0; i < NL; i++) m_lane[i] = IDLE;
         return;
      end
      if (read_strobe) begin
         case (mode)
            2'b00: begin
               m_lane[m_sel] = (q.size() > 0) ? q.pop_front() : IDLE;
               m_sel = (m_sel + 1) % NL;
            end
            2'b01: for (int i = 0; i < NL; i++) m_lane[i] = ATU_IN[i*NB +: NB];
            default: for (int i = 0; i < NL; i++) m_lane[i] = IDLE;
         endcase
      end
      if (write_signal) begin
         if (q.size() < DEPTH) q.push_back(data_in);
         else begin
            m_losing = 1'b1;
            if (m_ovf < 255) m_ovf++;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < NL; i++) chk($sformatf("lane%0d", i), lane(i), m_lane[i]);
      chk("level", level, q.size());
      chk("empty", empty, q.size() == 0);
      chk("full", full, q.size() == DEPTH);
      chk("losing_data", losing_data, m_losing);
      chk("ovf_cnt", ovf_cnt, m_ovf);
   endtask

   // inputs are set at negedge; model steps with the DUT edge; compare at next negedge
   task automatic drv(input logic [1:0] m, input logic w, input logic [31:0] d,
                      input logic s, input logic r = 1'b0);
      mode = m; write_signal = w; data_in = d; read_strobe = s; RST = r;
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      compare_all();
   endtask

   initial begin
      // reset
      drv(2'b00, 1'b0, '0, 1'b0, 1'b1);
      drv(2'b00, 1'b1, 32'h12345678, 1'b1, 1'b1);
      chk("rst_lane0", lane(0), IDLE);
      chk("rst_empty", empty, 1'b1);
      chk("rst_level", level, 0);

      // 1: six words, six strobes
      for (int k = 1; k <= 6; k++) drv(2'b00, 1'b1, 32'h11111111 * k, 1'b0);
      for (int k = 1; k <= 4; k++) drv(2'b00, 1'b0, '0, 1'b1);
      chk("t1_l3", lane(3), 32'h44444444);
      drv(2'b00, 1'b0, '0, 1'b1);
      drv(2'b00, 1'b0, '0, 1'b1);
      chk("t1_l0", lane(0), 32'h55555555);
      chk("t1_l1", lane(1), 32'h66666666);
      chk("t1_l2", lane(2), 32'h33333333);
      chk("t1_l3b", lane(3), 32'h44444444);
      chk("t1_empty", empty, 1'b1);

      // 2: overfill by four, then drain 16 (lane_sel starts at 2)
      for (int k = 1; k <= 20; k++) begin
         drv(2'b00, 1'b1, k, 1'b0);
         if (k == 16) begin chk("t2_full", full, 1'b1); chk("t2_level", level, 16); end
      end
      chk("t2_losing", losing_data, 1'b1);
      chk("t2_ovf", ovf_cnt, 4);
      for (int k = 1; k <= 16; k++) begin
         drv(2'b00, 1'b0, '0, 1'b1);
         chk("t2_pop", lane((k + 1) % 4), k);
      end

      // 3: full + write + strobe together
      for (int k = 1; k <= 16; k++) drv(2'b00, 1'b1, 32'h300 + k, 1'b0);
      drv(2'b00, 1'b1, 32'hC0FFEE00, 1'b1);
      chk("t3_level", level, 16);
      chk("t3_ovf", ovf_cnt, 4);
      chk("t3_head", lane(2), 32'h301);
      for (int k = 1; k <= 16; k++) drv(2'b00, 1'b0, '0, 1'b1);
      chk("t3_16th", lane(2), 32'hC0FFEE00);

      // 4: ATU pattern, then back to DTU restarts at lane 0
      drv(2'b00, 1'b1, 32'h4001, 1'b0);
      drv(2'b00, 1'b1, 32'h4002, 1'b0);
      for (int i = 0; i < NL; i++) ATU_IN[i*NB +: NB] = 32'hA0000000 + i;
      drv(2'b01, 1'b0, '0, 1'b1);
      chk("t4_atu0", lane(0), 32'hA0000000);
      chk("t4_atu3", lane(3), 32'hA0000003);
      chk("t4_level", level, 2);
      drv(2'b00, 1'b0, '0, 1'b1);
      chk("t4_dtu_l0", lane(0), 32'h4001);
      chk("t4_dtu_l1", lane(1), 32'hA0000001);

      // 5: no fall-through on empty
      drv(2'b00, 1'b0, '0, 1'b1);
      drv(2'b00, 1'b1, 32'hDEADBEEF, 1'b1);
      chk("t5_idle", lane(2), IDLE);
      drv(2'b00, 1'b0, '0, 1'b1);
      chk("t5_word", lane(3), 32'hDEADBEEF);

      // 6: overflow, one flush cycle with a write, then DTU
      drv(2'b11, 1'b0, '0, 1'b0);
      for (int k = 1; k <= 20; k++) drv(2'b00, 1'b1, 32'h500 + k, 1'b0);
      chk("t6_ovf", ovf_cnt, 4);
      drv(2'b11, 1'b1, 32'hBADBAD00, 1'b0);
      chk("t6_level", level, 0);
      chk("t6_losing", losing_data, 1'b0);
      chk("t6_ovfclr", ovf_cnt, 0);
      drv(2'b00, 1'b1, 32'h600, 1'b0);
      drv(2'b00, 1'b0, '0, 1'b1);
      chk("t6_l0", lane(0), 32'h600);
      drv(2'b00, 1'b0, '0, 1'b1);
      chk("t6_l1", lane(1), IDLE);

      // saturation of ovf_cnt
      for (int k = 0; k < 16 + 300; k++) drv(2'b00, 1'b1, k, 1'b0);
      chk("sat_ovf", ovf_cnt, 255);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int r;
         logic [1:0] m;
         r = $urandom_range(0, 19);
         m = (r < 13) ? 2'b00 : (r < 16) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
         if ($urandom_range(0, 9) == 0)
            for (int i = 0; i < NL; i++) ATU_IN[i*NB +: NB] = $urandom;
         drv(m, $urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 4,
             $urandom_range(0, 299) == 0);
      end

      // reset mid-stream
      for (int i = 0; i < NL; i++) ATU_IN[i*NB +: NB] = 32'h0F0F0F00 + i;
      drv(2'b01, 1'b1, 32'h1, 1'b1);
      drv(2'b00, 1'b1, 32'h2, 1'b1, 1'b1);
      for (int i = 0; i < NL; i++) chk("rst_mid", lane(i), IDLE);
      chk("rst_mid_level", level, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
